// File: rtl/uart_rx_fifo_param.sv
// uart_rx_fifo_param
//   Parametrised UART receiver. Start bits are qualified with an oversampled
//   mid-bit check. Parity and stop-bit modes are selected at runtime. Received
//   words go into a first-word-fall-through FIFO together with their parity and
//   framing error flags.
//
// Ports
//   ACLK, ARESETN     clock, asynchronous active-low reset
//   baud_div          oversample tick period minus 1, in ACLK cycles
//   parity_mode       00 none, 01 even, 10 odd, 11 none
//   two_stop          1 = check two stop bits
//   rx_in             asynchronous serial input
//   m_data/m_perr/m_ferr  head entry of the FIFO (forced to 0 while empty)
//   m_valid, m_ready  drain handshake
//   overrun           sticky flag: a word was dropped because the FIFO was full
//   clr_overrun       clears overrun (a drop in the same cycle wins)
//   fifo_level        current occupancy
//   state_dbg         current receiver FSM state, for checkers
//
// Handshake: m_valid is high whenever the FIFO holds a word. The head word is
// popped on every ACLK edge where m_valid && m_ready. m_ready while empty is ignored.
module uart_rx_fifo_param #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int FIFO_DEPTH = 16,
  parameter int DIV_W      = 16
) (
  input  logic                          ACLK,
  input  logic                          ARESETN,
  input  logic [DIV_W-1:0]              baud_div,
  input  logic [1:0]                    parity_mode,
  input  logic                          two_stop,
  input  logic                          rx_in,
  output logic [DATA_BITS-1:0]          m_data,
  output logic                          m_perr,
  output logic                          m_ferr,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic                          overrun,
  input  logic                          clr_overrun,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [2:0]                    state_dbg
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int SW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS);
  localparam int EW = DATA_BITS + 2;

  localparam logic [SW-1:0] HALF_M1  = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] FULL_M1  = SW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);
  localparam logic [PW:0]   DEPTH_V  = (PW + 1)'(FIFO_DEPTH);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP1  = 3'd4;
  localparam logic [2:0] S_STOP2  = 3'd5;

  // ---------------- synchroniser ----------------
  logic sync1, rxs;
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      sync1 <= 1'b1;
      rxs   <= 1'b1;
    end else begin
      sync1 <= rx_in;
      rxs   <= sync1;
    end
  end

  // ---------------- free-running tick generator ----------------
  logic [DIV_W-1:0] tick_cnt;
  logic             tick;
  assign tick = (tick_cnt == '0);

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN)  tick_cnt <= '0;
    else if (tick) tick_cnt <= baud_div;
    else           tick_cnt <= tick_cnt - 1'b1;
  end

  // ---------------- receiver FSM ----------------
  logic [2:0]           state;
  logic [SW-1:0]        samp_cnt;
  logic [BW-1:0]        bit_cnt;
  logic [DATA_BITS-1:0] data_sr;
  logic                 perr, ferr;
  logic [1:0]           pmode_l;
  logic                 two_l;
  logic                 armed;      // IDLE may only start after rxs was seen high
  logic                 push_pend;  // one-cycle push strobe after the last stop sample
  logic                 at_sample;
  logic                 par_en;

  assign state_dbg = state;
  assign par_en    = (pmode_l == 2'b01) || (pmode_l == 2'b10);
  assign at_sample = (samp_cnt == ((state == S_START) ? HALF_M1 : FULL_M1));

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state     <= S_IDLE;
      samp_cnt  <= '0;
      bit_cnt   <= '0;
      data_sr   <= '0;
      perr      <= 1'b0;
      ferr      <= 1'b0;
      pmode_l   <= 2'b00;
      two_l     <= 1'b0;
      armed     <= 1'b1;
      push_pend <= 1'b0;
    end else begin
      push_pend <= 1'b0;
      if (state == S_IDLE) begin
        if (rxs) begin
          armed <= 1'b1;
        end else if (armed) begin
          state    <= S_START;
          samp_cnt <= '0;
          bit_cnt  <= '0;
          perr     <= 1'b0;
          ferr     <= 1'b0;
          pmode_l  <= parity_mode;
          two_l    <= two_stop;
        end
      end else if (tick) begin
        if (!at_sample) begin
          samp_cnt <= samp_cnt + 1'b1;
        end else begin
          samp_cnt <= '0;
          case (state)
            S_START: state <= rxs ? S_IDLE : S_DATA;
            S_DATA: begin
              data_sr <= {rxs, data_sr[DATA_BITS-1:1]};
              bit_cnt <= bit_cnt + 1'b1;
              if (bit_cnt == LAST_BIT) state <= par_en ? S_PARITY : S_STOP1;
            end
            S_PARITY: begin
              // Even: total ones incl. parity bit must be even; odd: must be odd.
              if (pmode_l == 2'b01) perr <= ((^data_sr) != rxs);
              else                  perr <= ((^data_sr) == rxs);
              state <= S_STOP1;
            end
            S_STOP1: begin
              ferr <= ~rxs;
              if (two_l) begin
                state <= S_STOP2;
              end else begin
                push_pend <= 1'b1;
                armed     <= rxs;
                state     <= S_IDLE;
              end
            end
            S_STOP2: begin
              ferr      <= ferr | ~rxs;
              push_pend <= 1'b1;
              armed     <= rxs;
              state     <= S_IDLE;
            end
            default: state <= S_IDLE;
          endcase
        end
      end
    end
  end

  // ---------------- FWFT FIFO ----------------
  logic [EW-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0]   count;
  logic          full, do_pop, do_push, drop;
  logic [EW-1:0] head;

  assign full    = (count == DEPTH_V);
  assign m_valid = (count != '0);
  assign do_pop  = m_valid && m_ready;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign do_push = push_pend && (!full || do_pop);
  assign drop    = push_pend && full && !do_pop;

  always_ff @(posedge ACLK) begin
    if (do_push) mem[wr_ptr] <= {ferr, perr, data_sr};
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      overrun <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (drop)             overrun <= 1'b1;
      else if (clr_overrun) overrun <= 1'b0;
    end
  end

  // Memory is not reset, so the head is masked to give clean zeros when empty.
  assign head       = mem[rd_ptr];
  assign m_data     = m_valid ? head[DATA_BITS-1:0] : '0;
  assign m_perr     = m_valid ? head[DATA_BITS]     : 1'b0;
  assign m_ferr     = m_valid ? head[DATA_BITS+1]   : 1'b0;
  assign fifo_level = count;

endmodule

// File: tb/tb_uart_rx_fifo_param.sv
// Testbench for uart_rx_fifo_param: directed frames from the test plan plus
// randomized frames, all checked against a queue-based reference model.
module tb_uart_rx_fifo_param;

  localparam int DB    = 8;
  localparam int OS    = 16;
  localparam int DEPTH = 4;
  localparam int DW    = 16;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_STOP1 = 3'd4;

  logic          ACLK;
  logic          ARESETN;
  logic [DW-1:0] baud_div;
  logic [1:0]    parity_mode;
  logic          two_stop;
  logic          rx_in;
  logic [DB-1:0] m_data;
  logic          m_perr, m_ferr, m_valid;
  logic          m_ready;
  logic          overrun;
  logic          clr_overrun;
  logic [2:0]    fifo_level;
  logic [2:0]    state_dbg;

  int checks = 0;
  int errors = 0;

  // Reference model: queue of {ferr, perr, data} and a sticky overrun flag.
  logic [DB+1:0] exp_q[$];
  logic          exp_ovr;

  uart_rx_fifo_param #(
    .DATA_BITS(DB), .OVERSAMPLE(OS), .FIFO_DEPTH(DEPTH), .DIV_W(DW)
  ) dut (
    .ACLK(ACLK), .ARESETN(ARESETN), .baud_div(baud_div),
    .parity_mode(parity_mode), .two_stop(two_stop), .rx_in(rx_in),
    .m_data(m_data), .m_perr(m_perr), .m_ferr(m_ferr), .m_valid(m_valid),
    .m_ready(m_ready), .overrun(overrun), .clr_overrun(clr_overrun),
    .fifo_level(fifo_level), .state_dbg(state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  initial begin
    #900000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge ACLK);
    ARESETN = 1'b0;
    repeat (3) @(negedge ACLK);
    ARESETN = 1'b1;
    exp_q.delete();
    exp_ovr = 1'b0;
    repeat (2) @(negedge ACLK);
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_bit(input logic b);
    int n;
    n = (int'(baud_div) + 1) * OS;
    rx_in = b;
    repeat (n) @(negedge ACLK);
  endtask

  task automatic send_frame(input logic [DB-1:0] d, input logic [1:0] pm, input logic pbit,
                            input logic s1, input logic s2, input logic ts);
    parity_mode = pm;
    two_stop    = ts;
    drive_bit(1'b0);
    for (int i = 0; i < DB; i++) drive_bit(d[i]);
    if (pm == 2'b01 || pm == 2'b10) drive_bit(pbit);
    drive_bit(s1);
    if (ts) drive_bit(s2);
    drive_bit(1'b1);
    drive_bit(1'b1);
  endtask

  // Expected word from the frame's own rules: parity over data ones-count, stop bits must be 1.
  task automatic model_push(input logic [DB-1:0] d, input logic [1:0] pm, input logic pbit,
                            input logic s1, input logic s2, input logic ts);
    logic odd_ones, pe, fe;
    odd_ones = ($countones(d) % 2) == 1;
    if (pm == 2'b01)      pe = (odd_ones != pbit);
    else if (pm == 2'b10) pe = (odd_ones == pbit);
    else                  pe = 1'b0;
    fe = !s1 || (ts && !s2);
    if (exp_q.size() < DEPTH) exp_q.push_back({fe, pe, d});
    else                      exp_ovr = 1'b1;
  endtask

  task automatic frame(input logic [DB-1:0] d, input logic [1:0] pm, input logic pbit,
                       input logic s1, input logic s2, input logic ts);
    send_frame(d, pm, pbit, s1, s2, ts);
    model_push(d, pm, pbit, s1, s2, ts);
    check("level", 32'(fifo_level), 32'(exp_q.size()));
    check("overrun", 32'(overrun), 32'(exp_ovr));
  endtask

  task automatic pop_one(input string tag);
    logic [DB+1:0] e;
    @(negedge ACLK);
    if (exp_q.size() == 0) begin
      check({tag, "_empty_valid"}, 32'(m_valid), 32'd0);
    end else begin
      e = exp_q[0];
      check({tag, "_valid"}, 32'(m_valid), 32'd1);
      check({tag, "_data"}, 32'(m_data), 32'(e[DB-1:0]));
      check({tag, "_perr"}, 32'(m_perr), 32'(e[DB]));
      check({tag, "_ferr"}, 32'(m_ferr), 32'(e[DB+1]));
      m_ready = 1'b1;
      @(negedge ACLK);
      m_ready = 1'b0;
      void'(exp_q.pop_front());
    end
  endtask

  task automatic pop_all(input string tag);
    while (exp_q.size() > 0) pop_one(tag);
    check({tag, "_drained_level"}, 32'(fifo_level), 32'd0);
    check({tag, "_drained_valid"}, 32'(m_valid), 32'd0);
  endtask

  task automatic wait_state(input logic [2:0] st, output logic ok);
    ok = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      @(negedge ACLK);
      if (state_dbg == st) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic pulse_clr();
    @(negedge ACLK);
    clr_overrun = 1'b1;
    @(negedge ACLK);
    clr_overrun = 1'b0;
    exp_ovr = 1'b0;
    check("clr_overrun", 32'(overrun), 32'd0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic ok;
    logic [DB-1:0] d;
    logic [1:0] pm;
    logic pb, s1, s2, ts;
    logic [DB-1:0] rd;

    ARESETN = 1'b0; baud_div = '0; parity_mode = 2'b00; two_stop = 1'b0;
    rx_in = 1'b1; m_ready = 1'b0; clr_overrun = 1'b0;
    exp_ovr = 1'b0;
    repeat (3) @(negedge ACLK);
    check("rst_valid", 32'(m_valid), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
    check("rst_level", 32'(fifo_level), 32'd0);
    check("rst_data", 32'(m_data), 32'd0);
    check("rst_flags", 32'({m_perr, m_ferr}), 32'd0);
    ARESETN = 1'b1;
    repeat (4) @(negedge ACLK);

    // Single frame with push-to-valid latency check.
    fork
      send_frame(8'hA5, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0);
      begin
        wait_state(S_STOP1, ok);
        check("wait_stop1", 32'(ok), 32'd1);
        wait_state(S_IDLE, ok);
        check("wait_idle", 32'(ok), 32'd1);
        check("lat_push_cycle_valid", 32'(m_valid), 32'd0);
        @(negedge ACLK);
        check("lat_valid_rise", 32'(m_valid), 32'd1);
      end
    join
    model_push(8'hA5, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0);
    check("single_level", 32'(fifo_level), 32'd1);
    pop_all("single");

    // Parity modes.
    frame(8'h07, 2'b01, 1'b1, 1'b1, 1'b1, 1'b0);
    frame(8'h07, 2'b01, 1'b0, 1'b1, 1'b1, 1'b0);
    frame(8'h07, 2'b10, 1'b0, 1'b1, 1'b1, 1'b0);
    pop_all("parity");

    // Framing: second stop bit low, then an idle-line glitch.
    frame(8'h3C, 2'b00, 1'b0, 1'b1, 1'b0, 1'b1);
    pop_all("framing");
    @(negedge ACLK);
    rx_in = 1'b0;
    repeat (4) @(negedge ACLK);
    rx_in = 1'b1;
    repeat (3 * OS) @(negedge ACLK);
    check("glitch_level", 32'(fifo_level), 32'd0);

    // Break: line held low well past a frame gives exactly one error word.
    parity_mode = 2'b00; two_stop = 1'b0;
    rx_in = 1'b0;
    repeat (20 * OS) @(negedge ACLK);
    rx_in = 1'b1;
    repeat (3 * OS) @(negedge ACLK);
    model_push('0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0);
    check("break_level", 32'(fifo_level), 32'd1);
    pop_all("break");

    // Overrun: five frames into four entries.
    for (int i = 1; i <= 5; i++) frame(DB'(i), 2'b00, 1'b0, 1'b1, 1'b1, 1'b0);
    check("ovr_level", 32'(fifo_level), 32'd4);
    check("ovr_flag", 32'(overrun), 32'd1);
    check("ovr_head", 32'(m_data), 32'h01);
    pop_all("ovr");
    pulse_clr();

    // Full FIFO with a pop landing on the push cycle.
    for (int i = 0; i < 4; i++) frame(DB'(8'h11 + i), 2'b00, 1'b0, 1'b1, 1'b1, 1'b0);
    fork
      send_frame(8'h15, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0);
      begin
        wait_state(S_STOP1, ok);
        check("sp_wait_stop1", 32'(ok), 32'd1);
        wait_state(S_IDLE, ok);
        check("sp_wait_idle", 32'(ok), 32'd1);
        check("sp_head", 32'(m_data), 32'h11);
        m_ready = 1'b1;
        @(negedge ACLK);
        m_ready = 1'b0;
      end
    join
    void'(exp_q.pop_front());
    model_push(8'h15, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0);
    check("sp_level", 32'(fifo_level), 32'd4);
    check("sp_overrun", 32'(overrun), 32'd0);
    for (int i = 0; i < 3; i++) pop_one("sp");
    check("sp_last", 32'(m_data), 32'h15);
    pop_all("sp");

    // Randomized frames with random baud, modes, errors, pops and clears.
    for (int it = 0; it < 25; it++) begin
      baud_div = DW'($urandom_range(0, 2));
      d  = DB'($urandom);
      pm = 2'($urandom_range(0, 3));
      pb = 1'($urandom_range(0, 1));
      ts = 1'($urandom_range(0, 1));
      s1 = ($urandom_range(0, 5) != 0);
      s2 = ($urandom_range(0, 5) != 0);
      frame(d, pm, pb, s1, s2, ts);
      case ($urandom_range(0, 2))
        0: pop_all("rnd");
        1: pop_one("rnd");
        default: ;
      endcase
      if ($urandom_range(0, 4) == 0) pulse_clr();
    end
    pop_all("rnd_end");
    baud_div = '0;

    // Reset in the middle of DATA bit 3 with a full FIFO and overrun set.
    for (int i = 0; i < 5; i++) frame(DB'(8'h30 + i), 2'b00, 1'b0, 1'b1, 1'b1, 1'b0);
    rd = 8'h5A;
    parity_mode = 2'b00; two_stop = 1'b0;
    drive_bit(1'b0);
    for (int i = 0; i < 3; i++) drive_bit(rd[i]);
    rx_in = rd[3];
    repeat (OS / 2) @(negedge ACLK);
    #2;
    ARESETN = 1'b0;
    #1;
    check("mid_rst_valid", 32'(m_valid), 32'd0);
    check("mid_rst_level", 32'(fifo_level), 32'd0);
    check("mid_rst_overrun", 32'(overrun), 32'd0);
    check("mid_rst_data", 32'(m_data), 32'd0);
    rx_in = 1'b1;
    exp_q.delete();
    exp_ovr = 1'b0;
    repeat (3) @(negedge ACLK);
    ARESETN = 1'b1;
    repeat (4) @(negedge ACLK);
    check("post_rst_level", 32'(fifo_level), 32'd0);
    frame(8'h5A, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0);
    pop_all("post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo_param.md
Name: uart_rx_fifo_param

Overview:
Parametrised UART receiver with oversampled start-bit detection and runtime-selectable parity and stop-bit modes. It buffers received words in a first-word-fall-through FIFO with per-word error flags. It is the receive-side successor to the fixed 13 MHz / parity UART core. It sits behind the AXI register slave, which drains the FIFO through a valid/ready port and programs the mode inputs.

Parameters:
DATA_BITS, 8, data bits per frame, legal values 5..9
OVERSAMPLE, 16, oversample ticks per bit, even, legal values 8..32
FIFO_DEPTH, 16, FIFO entries, power of 2, legal values 2..256
DIV_W, 16, width of baud_div

Ports:
ACLK  in  1  clock
ARESETN  in  1  asynchronous active-low reset
baud_div  in  DIV_W  oversample tick period minus 1, in ACLK cycles
parity_mode  in  2  00 none, 01 even, 10 odd, 11 treated as none
two_stop  in  1  1 = check two stop bits
rx_in  in  1  serial input, asynchronous
m_data  out  DATA_BITS  FIFO head data
m_perr  out  1  parity error flag of head word
m_ferr  out  1  framing error flag of head word
m_valid  out  1  FIFO not empty
m_ready  in  1  consumer pop
overrun  out  1  sticky: a word was dropped because the FIFO was full
clr_overrun  in  1  clears overrun
fifo_level  out  clog2(FIFO_DEPTH)+1  current occupancy

Behaviour:
- Reset values (asynchronous, while ARESETN=0): m_valid=0, overrun=0, fifo_level=0, m_data/m_perr/m_ferr=0, FSM=IDLE, both synchroniser flops=1, tick counter=0.
- Reset mid-frame aborts the frame and stores no word.
- rx_in passes through a 2-flop synchroniser. All sampling uses the synchronised signal rxs.
- Tick generator: down-counter reloads with baud_div on reaching 0 and emits a 1-cycle tick. baud_div=0 gives a tick every cycle. The counter free-runs and is not resynchronised per frame.
- Mode inputs are latched at the start-edge detection and held for the whole frame.
- FSM states: IDLE, START, DATA, PARITY, STOP1, STOP2.
  - IDLE: rxs=0 on any cycle -> START, with the sample counter cleared.
  - START: on the tick where the sample counter reaches OVERSAMPLE/2-1, sample rxs.
    - rxs=1 -> false start; return to IDLE and store nothing.
    - rxs=0 -> DATA, with the sample counter cleared.
  - Later bits are each sampled on the tick where the sample counter reaches OVERSAMPLE-1, i.e. at mid-bit.
  - DATA: shift in DATA_BITS bits, LSB first -> PARITY if parity is enabled, else STOP1.
  - PARITY: even mode -> perr = (XOR of data bits) != sampled bit. Odd mode -> perr = (XOR of data bits) == sampled bit. Then -> STOP1.
  - STOP1: ferr = (rxs==0). Then -> STOP2 if two_stop=1, else push and -> IDLE in the same cycle.
  - STOP2: ferr |= (rxs==0). Then push and -> IDLE.
  - Return to IDLE happens at mid-stop, so a start edge half a bit later is caught.
- Push writes {ferr, perr, data} into the FIFO on the cycle after the final stop sample. m_valid rises the following cycle.
  - Latency: 1 cycle from push to m_valid.
  - Latency: 2 synchroniser cycles + 1 from a rx_in edge to the FSM reacting to it.
- FIFO behaviour:
  - FWFT: m_data/m_perr/m_ferr always show the head entry. They are don't-care when m_valid=0.
  - Pop occurs when m_valid && m_ready.
  - Pointers wrap modulo FIFO_DEPTH. fifo_level = number of entries stored.
  - Push while full with no pop: word dropped, overrun set to 1, contents unchanged.
  - Push and pop in the same cycle when full: both accepted, level unchanged, no overrun.
  - Push and pop in the same cycle when empty: push accepted, pop ignored (m_valid was 0), level becomes 1.
  - m_ready while empty: no effect.
- overrun: set on a dropped push, cleared by clr_overrun. Set has priority when both happen in the same cycle.
- Error words are stored, never discarded. A break (rx held low) gives data=0, ferr=1. The FSM then stays in IDLE→START churn only after rxs returns to 1: IDLE re-arms only once rxs has been sampled high.

Test Plan:
- Single frame: baud_div=0, OVERSAMPLE=16, no parity, 1 stop, send 0xA5 (16 clocks/bit) -> one word, m_data=0xA5, perr=0, ferr=0, fifo_level=1; pop with m_ready -> level 0, m_valid=0.
- Parity: even mode, send 0x07 with parity bit 1 -> perr=0; same frame with parity bit 0 -> perr=1. Odd mode, 0x07 with parity bit 0 -> perr=0.
- Framing: two_stop=1, send 0x3C with second stop bit low -> m_data=0x3C, ferr=1; glitch low for 4 clocks on idle line -> no word stored.
- Overrun: FIFO_DEPTH=4, m_ready=0, send 5 frames 0x01..0x05 -> level 4, overrun=1, head=0x01; pop all -> 0x01..0x04; pulse clr_overrun -> overrun=0.
- Full with simultaneous pop: level 4, assert m_ready on the cycle of the 5th push -> level stays 4, overrun=0, last entry=0x05.
- Reset mid-frame: deassert ARESETN during DATA bit 3 -> all outputs 0 immediately; after release, frame 0x5A is received correctly.
